// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB-Lite widths and encodings for the SRAM slave
package ahb_sram_slave_pkg;

  localparam int AHB_DATA_BITS  = 32;
  localparam int AHB_TRANS_BITS = 2;
  localparam int AHB_SIZE_BITS  = 3;
  localparam int AHB_RESP_BITS  = 2;

  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [AHB_SIZE_BITS-1:0] HSIZE_BYTE = 3'b000;
  localparam logic [AHB_SIZE_BITS-1:0] HSIZE_HALF = 3'b001;
  localparam logic [AHB_SIZE_BITS-1:0] HSIZE_WORD = 3'b010;

  localparam logic [AHB_RESP_BITS-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [AHB_RESP_BITS-1:0] HRESP_ERROR = 2'b01;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not
  function automatic logic trans_active(input logic [AHB_TRANS_BITS-1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lane_strobe.sv
// rtl/ahb_lane_strobe.sv - little-endian byte-lane mask and alignment check
module ahb_lane_strobe
  import ahb_sram_slave_pkg::*;
(
  input  logic [AHB_SIZE_BITS-1:0] size,
  input  logic [1:0]               addr_lo,
  output logic [3:0]               mask,
  output logic                     misalign
);

  // Decode transfer size and low address bits into lane enables; unsupported sizes flag as bad
  always_comb begin
    mask     = 4'b0000;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask     = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask     = 4'b1111;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave terminating transfers onto a single-port synchronous SRAM
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int MEM_AW      = 14,
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      HSEL,
  input  logic [AHB_DATA_BITS-1:0]  HADDR,
  input  logic [AHB_TRANS_BITS-1:0] HTRANS,
  input  logic                      HWRITE,
  input  logic [AHB_SIZE_BITS-1:0]  HSIZE,
  input  logic [AHB_DATA_BITS-1:0]  HWDATA,
  input  logic                      HREADY,
  output logic [AHB_DATA_BITS-1:0]  HRDATA,
  output logic                      HREADYOUT,
  output logic [AHB_RESP_BITS-1:0]  HRESP,
  output logic                      mem_cs,
  output logic [3:0]                mem_we,
  output logic [MEM_AW-1:0]         mem_addr,
  output logic [31:0]               mem_din,
  input  logic [31:0]               mem_dout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_ERR1    = 3'd4;
  localparam logic [2:0] S_ERR2    = 3'd5;

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] addr_q;
  logic [3:0]        mask_q;

  logic [3:0]  lane_mask;
  logic        lane_bad;
  logic [31:0] word_idx;
  logic        req_err;
  logic        accept;
  logic        done;
  logic [2:0]  next_xfer;
  logic        unused_haddr_hi;

  ahb_lane_strobe u_strobe (
    .size     (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .mask     (lane_mask),
    .misalign (lane_bad)
  );

  // Upper address bits are resolved by the decoder and never reach the SRAM
  assign unused_haddr_hi = ^HADDR[AHB_DATA_BITS-1:MEM_AW+2];

  assign word_idx  = 32'(HADDR[MEM_AW+1:2]);
  assign req_err   = lane_bad || (word_idx >= 32'(MEM_WORDS));
  assign accept    = HSEL && HREADY && trans_active(HTRANS);
  assign next_xfer = req_err ? S_ERR1 : (HWRITE ? S_WR : S_RD);

  // A data phase is completing (or the slave is idle), so a new address phase may be taken
  assign done = (state == S_IDLE) || (state == S_RD_DATA) || (state == S_ERR2) ||
                ((state == S_WR) && (cnt == 4'd0));

  // Transfer sequencing: wait-state countdown, read pipeline, two-cycle error response
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      mask_q <= 4'b0000;
    end else if (done) begin
      if (accept) begin
        state  <= next_xfer;
        cnt    <= 4'(WAIT_CYCLES);
        addr_q <= HADDR[MEM_AW+1:2];
        mask_q <= lane_mask;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_WR, S_RD: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_RD_DATA;
          end
        end
        S_ERR1:  state <= S_ERR2;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus response and SRAM strobes; SRAM access is suppressed in any cycle with reset asserted
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    mem_cs    = 1'b0;
    mem_we    = 4'b0000;
    mem_din   = 32'd0;
    case (state)
      S_WR: begin
        if (cnt != 4'd0) begin
          HREADYOUT = 1'b0;
        end else begin
          mem_cs  = !rst;
          mem_we  = rst ? 4'b0000 : mask_q;
          mem_din = rst ? 32'd0 : HWDATA;
        end
      end
      S_RD: begin
        HREADYOUT = 1'b0;
        mem_cs    = (cnt == 4'd0) && !rst;
      end
      S_RD_DATA: HRDATA = mem_dout;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      S_ERR2:  HRESP = HRESP_ERROR;
      default: HREADYOUT = 1'b1;
    endcase
  end

  assign mem_addr = addr_q;

endmodule
